// File: rtl/store_log_pkg.sv
// store_log_pkg: shared types and constants for the store UART logger.
// Holds the frame sync byte, frame length, FIFO entry type and TX states.
package store_log_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 6;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } store_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Byte idx of the frame: sync, addr, then data MSB first.
    function automatic logic [7:0] frame_byte(
        input store_entry_t e,
        input logic [2:0]   idx
    );
        logic [7:0] b;
        b = e.data[7:0];
        case (idx)
            3'd0: b = SYNC_BYTE;
            3'd1: b = e.addr;
            3'd2: b = e.data[31:24];
            3'd3: b = e.data[23:16];
            3'd4: b = e.data[15:8];
            default: b = e.data[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/store_uart_logger_tx.sv
// uart_tx_byte: single-byte UART serializer, LSB first, 8N1 or 8E1.
// Ports: clk, rst_n, start/data in (accepted when idle or on done),
// done out (last stop-bit cycle), tx out (registered, idle high).
// Optional parity bit built when STORE_UART_PARITY_EN is defined.
module uart_tx_byte
    import store_log_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          wrap;
`ifdef STORE_UART_PARITY_EN
    logic          par_q, par_d;
`endif

    always_comb begin
        wrap    = (baud_q == CW'(CLKS_PER_BIT - 1));
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done    = 1'b0;
`ifdef STORE_UART_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    baud_d  = '0;
                    sh_d    = data;
`ifdef STORE_UART_PARITY_EN
                    par_d   = ^data;
`endif
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (wrap) begin
                    baud_d = '0;
                    sh_d   = sh_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef STORE_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef STORE_UART_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_d = STOP;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (wrap) begin
                    done   = 1'b1;
                    baud_d = '0;
                    // Next byte of the frame starts with no idle gap.
                    if (start) begin
                        state_d = START;
                        sh_d    = data;
`ifdef STORE_UART_PARITY_EN
                        par_d   = ^data;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        // Line level is registered from the next state to avoid glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
`ifdef STORE_UART_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            tx_q    <= 1'b1;
`ifdef STORE_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef STORE_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/store_uart_logger.sv
// store_uart_logger: buffers every store in a FIFO and sends each as a
// 6-byte UART frame (A5, addr[7:0], data MSB first).
// Ports: clk, rst_n, MemWriteM/ALUResultM/WriteDataM store bus,
// clear_ovf in; uart_tx, busy, fifo_level, overflow out.
// Macro STORE_UART_PARITY_EN selects 8E1 instead of 8N1.
module store_uart_logger
    import store_log_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        MemWriteM,
    input  logic [31:0]                 ALUResultM,
    input  logic [31:0]                 WriteDataM,
    input  logic                        clear_ovf,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    store_entry_t  mem [FIFO_DEPTH];
    store_entry_t  entry_in;
    store_entry_t  frame_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q;
    logic [2:0]    idx_q;
    logic          act_q;
    logic          ovf_q;
    logic          full, empty, pop, push, drop;
    logic          done, last, nxt, start;
    logic [7:0]    sbyte;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^ALUResultM[31:8];

    assign entry_in = '{addr: ALUResultM[7:0], data: WriteDataM};

    assign full  = (lvl_q == LW'(FIFO_DEPTH));
    assign empty = (lvl_q == '0);
    assign pop   = !act_q && !empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push  = MemWriteM && (!full || pop);
    assign drop  = MemWriteM && !push;

    assign last  = (idx_q == 3'(FRAME_BYTES - 1));
    assign nxt   = done && !last;
    assign start = pop || nxt;
    assign sbyte = pop ? SYNC_BYTE : frame_byte(frame_q, idx_q + 3'd1);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .data (sbyte),
        .done (done),
        .tx   (uart_tx)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            lvl_q   <= '0;
            frame_q <= '0;
            idx_q   <= 3'd0;
            act_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q    <= rd_q + AW'(1);
                frame_q <= mem[rd_q];
                idx_q   <= 3'd0;
                act_q   <= 1'b1;
            end else if (nxt) begin
                idx_q <= idx_q + 3'd1;
            end else if (done) begin
                act_q <= 1'b0;
            end
            unique case (1'b1)
                push && !pop: lvl_q <= lvl_q + LW'(1);
                pop && !push: lvl_q <= lvl_q - LW'(1);
                default:      lvl_q <= lvl_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign busy       = act_q;
    assign fifo_level = lvl_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_store_uart_logger.sv
// tb_store_uart_logger: self-checking bench for store_uart_logger.
// Table vectors, hand sequences and a queue-based reference model.
module tb_store_uart_logger;

    localparam int C = 4;
    localparam int D = 4;
`ifdef STORE_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = 6 * NB * C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic        clear_ovf = 1'b0;
    logic        uart_tx;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        overflow;

    int n_pass = 0;
    int n_total = 0;

    store_uart_logger #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemWriteM (MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .clear_ovf (clear_ovf),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .fifo_level(fifo_level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference model: a queue of stores and a transmitter that is busy
    // for one frame time after each pop.
    logic [39:0] mq[$];
    logic [7:0]  exp_bytes[$];
    int          busy_left = 0;
    bit          m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit m_pop;
        bit m_push;
        logic [39:0] e;
        if (!rst_n) begin
            mq.delete();
            exp_bytes.delete();
            busy_left = 0;
            m_ovf = 1'b0;
        end else begin
            m_pop  = (busy_left == 0) && (mq.size() > 0);
            m_push = MemWriteM && ((mq.size() < D) || m_pop);
            if (m_pop) begin
                e = mq.pop_front();
                exp_bytes.push_back(8'hA5);
                exp_bytes.push_back(e[39:32]);
                exp_bytes.push_back(e[31:24]);
                exp_bytes.push_back(e[23:16]);
                exp_bytes.push_back(e[15:8]);
                exp_bytes.push_back(e[7:0]);
                busy_left = FRAME;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (m_push) begin
                mq.push_back({ALUResultM[7:0], WriteDataM});
            end else if (MemWriteM) begin
                m_ovf = 1'b1;
            end else if (clear_ovf) begin
                m_ovf = 1'b0;
            end
        end
    end

    // Line decoder plus per-cycle comparison against the model.
    bit         rx_on = 1'b0;
    int         rx_cyc = 0;
    logic [7:0] rx_b = '0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        int k;
        if (!rst_n) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (uart_tx == 1'b0) begin
                rx_on  = 1'b1;
                rx_cyc = 0;
            end
        end else begin
            rx_cyc++;
            if (rx_cyc % C == C / 2) begin
                k = rx_cyc / C;
                if (k == 0) begin
                    chk("start_bit", uart_tx, 1'b0);
                end else if (k <= 8) begin
                    rx_b[k-1] = uart_tx;
`ifdef STORE_UART_PARITY_EN
                end else if (k == 9) begin
                    chk("parity_bit", uart_tx, ^rx_b);
`endif
                end else begin
                    chk("stop_bit", uart_tx, 1'b1);
                    rx_log.push_back(rx_b);
                    chk("rx_expected", exp_bytes.size() > 0, 1'b1);
                    if (exp_bytes.size() > 0) begin
                        chk("rx_byte", rx_b, exp_bytes.pop_front());
                    end
                    rx_on = 1'b0;
                end
            end
        end
        chk("level", fifo_level, mq.size());
        chk("busy", busy, busy_left > 0);
        chk("overflow", overflow, m_ovf);
        if (busy_left == 0) begin
            chk("tx_idle", uart_tx, 1'b1);
        end
    end

    typedef struct {
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
        logic        clr;
        int          lvl;
        logic        ovf;
        logic        bsy;
    } vec_t;

    vec_t       tbl[9];
    logic [7:0] exp1[6];

    initial begin
        int cnt;
        int p;
        int snap;

        tbl[0] = '{1'b1, 8'h11, 32'h1111_1111, 1'b0, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 32'h2222_2222, 1'b0, 1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 8'h33, 32'h07A5_C307, 1'b0, 2, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 8'h44, 32'h4444_0001, 1'b0, 3, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 8'h55, 32'h5555_8000, 1'b0, 4, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 8'h66, 32'h6666_6666, 1'b0, 4, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 8'h77, 32'h7777_7777, 1'b1, 4, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 32'h0000_0000, 1'b1, 4, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 32'h0000_0000, 1'b0, 4, 1'b0, 1'b1};
        exp1 = '{8'hA5, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single store and its frame
        rx_log.delete();
        MemWriteM = 1'b1;
        ALUResultM = 32'hFFFF_FF10;
        WriteDataM = 32'hDEAD_BEEF;
        @(negedge clk);
        MemWriteM = 1'b0;
        chk("single_tx_edge1", uart_tx, 1'b1);
        chk("single_level", fifo_level, 3'd1);
        @(negedge clk);
        chk("single_tx_edge2", uart_tx, 1'b0);
        chk("single_level_pop", fifo_level, 3'd0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        chk("single_busy_len", cnt, FRAME);
        chk("single_rx_count", rx_log.size(), 6);
        for (int i = 0; i < 6 && i < rx_log.size(); i++) begin
            chk("single_rx_byte", rx_log[i], exp1[i]);
        end
        repeat (3) @(negedge clk);

        // Burst, overflow and clear sequence
        for (int i = 0; i < 9; i++) begin
            MemWriteM  = tbl[i].we;
            ALUResultM = {24'h0, tbl[i].a};
            WriteDataM = tbl[i].d;
            clear_ovf  = tbl[i].clr;
            @(negedge clk);
            chk("tbl_level", fifo_level, tbl[i].lvl);
            chk("tbl_ovf", overflow, tbl[i].ovf);
            chk("tbl_busy", busy, tbl[i].bsy);
        end
        MemWriteM = 1'b0;
        clear_ovf = 1'b0;

        // Store while full on the pop edge
        cnt = 0;
        while (busy === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        chk("full_wait", busy, 1'b0);
        chk("full_level_pre", fifo_level, 3'd4);
        MemWriteM = 1'b1;
        ALUResultM = 32'h0000_00C3;
        WriteDataM = 32'hCAFE_F00D;
        @(negedge clk);
        MemWriteM = 1'b0;
        chk("full_pop_level", fifo_level, 3'd4);
        chk("full_pop_busy", busy, 1'b1);
        chk("full_pop_ovf", overflow, 1'b0);

        // Random traffic against the model
        p = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) p = $urandom_range(1, 30);
            MemWriteM  = ($urandom_range(0, 99) < p);
            ALUResultM = $urandom;
            WriteDataM = $urandom;
            clear_ovf  = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        MemWriteM = 1'b0;
        clear_ovf = 1'b0;

        cnt = 0;
        while ((fifo_level != 0 || busy) && cnt < 8000) begin
            cnt++;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("drain_idle", busy, 1'b0);
        chk("drain_bytes_left", exp_bytes.size(), 0);

        // Reset in the middle of a byte
        MemWriteM = 1'b1;
        WriteDataM = 32'h1234_5678;
        @(negedge clk);
        WriteDataM = 32'h9ABC_DEF0;
        @(negedge clk);
        MemWriteM = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", uart_tx, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_level", fifo_level, 3'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        snap = rx_log.size();
        repeat (400) @(negedge clk);
        chk("post_rst_no_bytes", rx_log.size(), snap);
        chk("post_rst_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
